// File: rtl/agc_gain_ctrl_if.sv
// AGC gain controller bus: power-estimate input, loop control, sample stream
// in and out, and the loop status outputs.
interface agc_gain_ctrl_if #(
    parameter int DWIDTH = 27,
    parameter int EWIDTH = 48,
    parameter int GWIDTH = 18
);
    logic signed [EWIDTH-1:0] Ema_In;
    logic                     Ema_Valid;
    logic signed [EWIDTH-1:0] Target;
    logic                     Loop_En;
    logic signed [DWIDTH-1:0] Sample_In;
    logic                     Sample_Valid;
    logic signed [DWIDTH-1:0] Sample_Out;
    logic                     Valid_Out;
    logic        [GWIDTH-1:0] Gain_Out;
    logic                     Locked;
    logic                     Sat;

    modport master (
        output Ema_In, Ema_Valid, Target, Loop_En, Sample_In, Sample_Valid,
        input  Sample_Out, Valid_Out, Gain_Out, Locked, Sat
    );

    modport slave (
        input  Ema_In, Ema_Valid, Target, Loop_En, Sample_In, Sample_Valid,
        output Sample_Out, Valid_Out, Gain_Out, Locked, Sat
    );
endinterface

// File: rtl/agc_gain_ctrl.sv
// Automatic gain control loop: steers a Q2.16 gain so the measured power
// estimate tracks a setpoint, and applies that gain to a sample stream through
// a two-stage multiply / shift-saturate pipeline.
module agc_gain_ctrl #(
    parameter int                DWIDTH     = 27,
    parameter int                EWIDTH     = 48,
    parameter int                GWIDTH     = 18,
    parameter int                MU_SHIFT   = 10,
    parameter int                SETTLE_CNT = 64,
    parameter logic [EWIDTH-1:0] LOCK_TH    = 48'h0000_0100_0000,
    parameter int                LOCK_CNT   = 16,
    parameter logic [GWIDTH-1:0] GAIN_MIN   = 18'h00400,
    parameter logic [GWIDTH-1:0] GAIN_MAX   = 18'h3FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    agc_gain_ctrl_if.slave bus
);

    localparam int PW = DWIDTH + GWIDTH + 1;
    localparam int XW = EWIDTH + 2;
    localparam int SW = $clog2(SETTLE_CNT + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CNT - 1);
    localparam logic [LW-1:0]        LOCK_FULL   = LW'(LOCK_CNT);
    localparam logic [GWIDTH-1:0]    GAIN_ONE    = GWIDTH'(1 << 16);
    localparam logic signed [XW-1:0] GAIN_LO     = $signed({{(XW-GWIDTH){1'b0}}, GAIN_MIN});
    localparam logic signed [XW-1:0] GAIN_HI     = $signed({{(XW-GWIDTH){1'b0}}, GAIN_MAX});
    localparam logic signed [PW-1:0] SAMP_HI     = $signed({{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] SAMP_LO     = $signed({{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, SETTLE, TRACK} state_t;

    // Clamp a widened gain sum into [GAIN_MIN, GAIN_MAX]; MSB flags a clamp.
    function automatic logic [GWIDTH:0] clamp_gain(input logic signed [XW-1:0] v);
        logic [GWIDTH:0] res;
        if (v < GAIN_LO) begin
            res = {1'b1, GAIN_MIN};
        end else if (v > GAIN_HI) begin
            res = {1'b1, GAIN_MAX};
        end else begin
            res = {1'b0, v[GWIDTH-1:0]};
        end
        return res;
    endfunction

    // Drop the 16 gain fraction bits (floor) and saturate to the sample width.
    function automatic logic [DWIDTH-1:0] sat_sample(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        logic [DWIDTH-1:0]    res;
        s = p >>> 16;
        if (s > SAMP_HI) begin
            res = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (s < SAMP_LO) begin
            res = {1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            res = s[DWIDTH-1:0];
        end
        return res;
    endfunction

    state_t            state_q;
    logic [SW-1:0]     settle_cnt_q;

    logic [GWIDTH-1:0] gain_d, gain_q;
    logic              sat_d, sat_q;
    logic [LW-1:0]     lock_cnt_d, lock_cnt_q;

    logic signed [EWIDTH:0] err;
    logic signed [EWIDTH:0] delta;
    logic [EWIDTH:0]        err_abs;
    logic signed [XW-1:0]   gain_sum;
    logic [GWIDTH:0]        clamp_res;
    logic                   upd;

    logic signed [PW-1:0] samp_ext, gain_ext;
    logic signed [PW-1:0] prod_p1_d, prod_p1_q;
    logic                 vld_p1_q, vld_p2_q;
    logic [DWIDTH-1:0]    sample_out_d, sample_out_q;

    // Loop sequencer: idle until enabled, discard SETTLE_CNT estimates, then track.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
        end else if (!bus.Loop_En) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q      <= SETTLE;
                    settle_cnt_q <= '0;
                end
                SETTLE: begin
                    if (bus.Ema_Valid) begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= TRACK;
                        end
                    end
                end
                TRACK:   state_q <= TRACK;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gain step from the power error, clamp, saturation flag and lock counting.
    always_comb begin
        err        = $signed({bus.Target[EWIDTH-1], bus.Target})
                   - $signed({bus.Ema_In[EWIDTH-1], bus.Ema_In});
        delta      = err >>> (16 + MU_SHIFT);
        err_abs    = err[EWIDTH] ? -err : err;
        gain_sum   = $signed({delta[EWIDTH], delta}) + $signed({{(XW-GWIDTH){1'b0}}, gain_q});
        clamp_res  = clamp_gain(gain_sum);
        upd        = (state_q == TRACK) && bus.Loop_En && bus.Ema_Valid;
        gain_d     = gain_q;
        sat_d      = sat_q;
        lock_cnt_d = lock_cnt_q;
        if (!bus.Loop_En) begin
            lock_cnt_d = '0;
        end else if (upd) begin
            gain_d = clamp_res[GWIDTH-1:0];
            sat_d  = clamp_res[GWIDTH];
            if (err_abs < {1'b0, LOCK_TH}) begin
                lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? LOCK_FULL : lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    // Loop state registers; gain comes out of reset at unity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_q     <= GAIN_ONE;
            sat_q      <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            gain_q     <= gain_d;
            sat_q      <= sat_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Sample path: multiply by the registered (pre-update) gain, then shift/saturate.
    always_comb begin
        samp_ext     = {{(GWIDTH+1){bus.Sample_In[DWIDTH-1]}}, bus.Sample_In};
        gain_ext     = {{(DWIDTH+1){1'b0}}, gain_q};
        prod_p1_d    = samp_ext * gain_ext;
        sample_out_d = vld_p1_q ? sat_sample(prod_p1_q) : sample_out_q;
    end

    // ---- stage p1: product register (data only) ----
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
    end

    // ---- stage p2: valid pipeline and held output sample ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            sample_out_q <= '0;
        end else begin
            vld_p1_q     <= bus.Sample_Valid;
            vld_p2_q     <= vld_p1_q;
            sample_out_q <= sample_out_d;
        end
    end

    assign bus.Sample_Out = sample_out_q;
    assign bus.Valid_Out  = vld_p2_q;
    assign bus.Gain_Out   = gain_q;
    assign bus.Locked     = (lock_cnt_q == LOCK_FULL);
    assign bus.Sat        = sat_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Bench for agc_gain_ctrl: directed steps plus randomized traffic, every cycle
// compared against a behavioural model of the gain loop and sample scaler.
module tb_agc_gain_ctrl;
    localparam int     DW = 27;
    localparam int     EW = 48;
    localparam int     GW = 18;
    localparam int     MU = 10;
    localparam int     SC = 4;
    localparam int     LC = 16;
    localparam longint LOCK_TH_V = 64'sh100_0000;
    localparam longint GMIN = 64'sh400;
    localparam longint GMAX = 64'sh3FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    agc_gain_ctrl_if #(.DWIDTH(DW), .EWIDTH(EW), .GWIDTH(GW)) bus ();

    agc_gain_ctrl #(
        .DWIDTH(DW), .EWIDTH(EW), .GWIDTH(GW), .MU_SHIFT(MU),
        .SETTLE_CNT(SC), .LOCK_CNT(LC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    longint m_gain;
    bit     m_sat;
    int     m_lock;
    bit     m_armed;
    int     m_pulses;
    bit     m_p1_v;
    longint m_p1_val;
    bit     m_vout;
    longint m_out;

    function automatic longint scale(input longint s, input longint g);
        longint v;
        v = (s * g) >>> 16;
        if (v > (64'sh1 << (DW-1)) - 1) v = (64'sh1 << (DW-1)) - 1;
        if (v < -(64'sh1 << (DW-1)))    v = -(64'sh1 << (DW-1));
        return v;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        longint err, nv, aerr;
        if (!rst_n) begin
            m_gain = 64'sh10000; m_sat = 1'b0; m_lock = 0; m_armed = 1'b0; m_pulses = 0;
            m_p1_v = 1'b0; m_vout = 1'b0; m_out = 0;
            return;
        end
        m_vout = m_p1_v;
        if (m_p1_v) m_out = m_p1_val;
        m_p1_v = bus.Sample_Valid;
        if (bus.Sample_Valid) m_p1_val = scale(longint'(bus.Sample_In), m_gain);
        if (!bus.Loop_En) begin
            m_armed = 1'b0; m_pulses = 0; m_lock = 0;
        end else if (!m_armed) begin
            m_armed = 1'b1; m_pulses = 0;
        end else if (bus.Ema_Valid) begin
            if (m_pulses < SC) begin
                m_pulses++;
            end else begin
                err = longint'(bus.Target) - longint'(bus.Ema_In);
                nv  = m_gain + (err >>> (16 + MU));
                if (nv < GMIN) begin
                    m_gain = GMIN; m_sat = 1'b1;
                end else if (nv > GMAX) begin
                    m_gain = GMAX; m_sat = 1'b1;
                end else begin
                    m_gain = nv; m_sat = 1'b0;
                end
                aerr = (err < 0) ? -err : err;
                if (aerr < LOCK_TH_V) m_lock = (m_lock < LC) ? m_lock + 1 : LC;
                else                  m_lock = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] mask;
        mask = (64'd1 << DW) - 1;
        chk("gain_out",   {46'b0, bus.Gain_Out},   64'(m_gain));
        chk("sat",        {63'b0, bus.Sat},        {63'b0, m_sat});
        chk("locked",     {63'b0, bus.Locked},     {63'b0, (m_lock == LC)});
        chk("valid_out",  {63'b0, bus.Valid_Out},  {63'b0, m_vout});
        chk("sample_out", {37'b0, bus.Sample_Out}, 64'(m_out) & mask);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rand_sample();
        bus.Sample_Valid = ($urandom_range(0, 3) != 0);
        bus.Sample_In    = DW'($urandom);
    endtask

    initial begin
        longint tgt, off, held;
        bus.Ema_In = '0; bus.Ema_Valid = 1'b0; bus.Target = '0; bus.Loop_En = 1'b0;
        bus.Sample_In = '0; bus.Sample_Valid = 1'b0;

        // Reset state
        step(); step();
        chk("rst_gain",  {46'b0, bus.Gain_Out},   64'h10000);
        chk("rst_valid", {63'b0, bus.Valid_Out},  64'h0);
        chk("rst_sout",  {37'b0, bus.Sample_Out}, 64'h0);

        // Unity gain pass-through with loop disabled
        rst_n = 1'b1;
        bus.Sample_In = 27'h0040000; bus.Sample_Valid = 1'b1;
        step();
        bus.Sample_Valid = 1'b0;
        step();
        chk("unity_sout",  {37'b0, bus.Sample_Out}, 64'h0040000);
        chk("unity_valid", {63'b0, bus.Valid_Out},  64'h1);
        for (int i = 0; i < 20; i++) begin rand_sample(); step(); end

        // Settling: SC estimates ignored, then one update of +1 LSB
        bus.Sample_Valid = 1'b0;
        bus.Loop_En = 1'b1;
        step();
        bus.Ema_Valid = 1'b1;
        for (int i = 0; i < SC; i++) begin
            bus.Ema_In = EW'({$urandom, $urandom});
            step();
        end
        chk("settle_gain", {46'b0, bus.Gain_Out}, 64'h10000);
        bus.Target = EW'(64'sh1 << 26); bus.Ema_In = '0;
        step();
        chk("first_upd", {46'b0, bus.Gain_Out}, 64'h10001);

        // Lock acquisition on zero error, loss on |err| == LOCK_TH
        tgt = longint'($urandom) << 8;
        bus.Target = EW'(tgt); bus.Ema_In = EW'(tgt);
        for (int i = 0; i < LC - 1; i++) step();
        chk("lock_15", {63'b0, bus.Locked}, 64'h0);
        step();
        chk("lock_16", {63'b0, bus.Locked}, 64'h1);
        bus.Ema_In = EW'(tgt - LOCK_TH_V);
        step();
        chk("lock_lost", {63'b0, bus.Locked}, 64'h0);

        // Randomized tracking with back-to-back and sparse estimates plus samples
        tgt = 64'sh1 << 36;
        bus.Target = EW'(tgt);
        for (int i = 0; i < 300; i++) begin
            bus.Ema_Valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) off = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
            else                           off = longint'($urandom_range(0, 1 << 30)) - (1 << 29);
            bus.Ema_In = EW'(tgt + off);
            rand_sample();
            step();
        end

        // Large negative error: gain walks down and clamps at GAIN_MIN
        bus.Sample_Valid = 1'b0;
        bus.Target = '0; bus.Ema_In = EW'(64'sh1 << 40); bus.Ema_Valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("clamp_min", {46'b0, bus.Gain_Out}, 64'h400);
        chk("sat_min",   {63'b0, bus.Sat},      64'h1);

        // Large positive error: clamp at GAIN_MAX, then saturate the sample path
        bus.Target = EW'(64'sh1 << 40); bus.Ema_In = '0;
        for (int i = 0; i < 20; i++) step();
        chk("clamp_max", {46'b0, bus.Gain_Out}, 64'h3FFFF);
        bus.Ema_Valid = 1'b0;
        bus.Sample_In = 27'h3FFFFFF; bus.Sample_Valid = 1'b1;
        step();
        bus.Sample_In = 27'h4000000;
        step();
        chk("pos_sat", {37'b0, bus.Sample_Out}, 64'h3FFFFFF);
        bus.Sample_Valid = 1'b0;
        step();
        chk("neg_sat", {37'b0, bus.Sample_Out}, 64'h4000000);
        step();
        chk("hold_sout",  {37'b0, bus.Sample_Out}, 64'h4000000);
        chk("hold_valid", {63'b0, bus.Valid_Out},  64'h0);

        // Enable drop mid-track: gain holds, lock clears
        bus.Ema_Valid = 1'b1; bus.Target = EW'(tgt);
        for (int i = 0; i < 6; i++) begin
            bus.Ema_In = EW'(tgt + longint'($urandom_range(0, 1 << 30)) - (1 << 29));
            rand_sample();
            step();
        end
        held = m_gain;
        bus.Loop_En = 1'b0; bus.Ema_In = EW'(64'sh1 << 40);
        step();
        chk("en_drop_gain", {46'b0, bus.Gain_Out}, 64'(held));
        chk("en_drop_lock", {63'b0, bus.Locked},   64'h0);
        for (int i = 0; i < 4; i++) begin rand_sample(); step(); end

        // Reset mid-stream overrides enable and valids
        bus.Loop_En = 1'b1; bus.Sample_Valid = 1'b1; bus.Sample_In = 27'h0123456;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_gain",  {46'b0, bus.Gain_Out},   64'h10000);
        chk("mid_rst_valid", {63'b0, bus.Valid_Out},  64'h0);
        chk("mid_rst_sout",  {37'b0, bus.Sample_Out}, 64'h0);
        rst_n = 1'b1; bus.Sample_Valid = 1'b0; bus.Loop_En = 1'b0; bus.Ema_Valid = 1'b0;
        step();
        chk("no_stale_1", {63'b0, bus.Valid_Out}, 64'h0);
        step();
        chk("no_stale_2", {63'b0, bus.Valid_Out}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/agc_gain_ctrl.md
AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 27, signed sample width, 18 fractional bits.
REQ-002 SHALL have parameter EWIDTH, default 48, signed power-estimate width, 32 fractional bits.
REQ-003 SHALL have parameter GWIDTH, default 18, unsigned gain width, Q2.16.
REQ-004 SHALL have parameter MU_SHIFT, default 10, loop step as an extra arithmetic right shift.
REQ-005 SHALL have parameter SETTLE_CNT, default 64, number of estimates ignored after enable.
REQ-006 SHALL have parameters LOCK_TH, default 48'h0000_0100_0000, and LOCK_CNT, default 16, the lock window and the required consecutive hits.
REQ-007 SHALL have parameters GAIN_MIN, default 18'h00400, and GAIN_MAX, default 18'h3FFFF, the gain clamp bounds.
REQ-008 Ports (name direction width meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- Ema_In  in  EWIDTH  signed power estimate
- Ema_Valid  in  1  Ema_In qualifier
- Target  in  EWIDTH  signed power setpoint, quasi-static
- Loop_En  in  1  loop enable
- Sample_In  in  DWIDTH  signed sample
- Sample_Valid  in  1  Sample_In qualifier
- Sample_Out  out  DWIDTH  gain-scaled sample
- Valid_Out  out  1  Sample_Out qualifier
- Gain_Out  out  GWIDTH  current gain register
- Locked  out  1  loop converged
- Sat  out  1  last update clamped

Function
REQ-009 SHALL implement FSM states IDLE, SETTLE and TRACK.
REQ-010 IDLE SHALL move to SETTLE on Loop_En=1 and clear the settle counter.
REQ-011 SETTLE SHALL count Ema_Valid pulses without updating the gain, and SHALL enter TRACK on the cycle after the SETTLE_CNT-th pulse.
REQ-012 Loop_En=0 SHALL force IDLE from any state on the next edge; the gain SHALL hold (not reset); Locked and the lock counter SHALL clear.
REQ-013 In TRACK, each Ema_Valid SHALL compute err = Target - Ema_In at EWIDTH+1 bits and delta = err >>> (16+MU_SHIFT), arithmetic and sign-preserving.
REQ-014 The gain update SHALL be gain_next = clamp(gain + delta, GAIN_MIN, GAIN_MAX), registered one cycle after Ema_Valid.
REQ-015 Sat SHALL be set on the update when the clamp engaged, cleared on an unclamped update, and held otherwise.
REQ-016 The lock counter SHALL increment on each TRACK update with |err| < LOCK_TH (saturating at LOCK_CNT) and reset to 0 otherwise; Locked = (counter == LOCK_CNT).
REQ-017 Sample path: Sample_Out = saturate_DWIDTH((Sample_In * gain) >>> 16) using floor (truncation); 2-cycle latency; Valid_Out = Sample_Valid delayed 2 cycles.
REQ-018 On overflow, Sample_Out SHALL saturate to +2^(DWIDTH-1)-1 or -2^(DWIDTH-1).
REQ-019 If a gain update and Sample_Valid fall in the same cycle, that sample SHALL use the pre-update gain.
REQ-020 Sample_Out SHALL hold its last value when Valid_Out=0.
REQ-021 Ema_Valid pulses arriving in back-to-back cycles SHALL each produce one update, with none dropped.

Reset
REQ-022 rst_n=0 at a clock edge SHALL set: state IDLE, gain 18'h10000 (1.0), Gain_Out 18'h10000, Sample_Out 0, Valid_Out 0, Locked 0, Sat 0, all counters 0, sample pipeline flushed.
REQ-023 Reset asserted mid-operation SHALL take precedence over Loop_En and all valids in the same cycle.

Verification
REQ-024 Reset, Loop_En=0, Sample_In=27'h0040000 valid -> Sample_Out=27'h0040000 two cycles later, Gain_Out=18'h10000.
REQ-025 SETTLE_CNT=4, Loop_En=1, 4 Ema_Valid pulses -> gain unchanged; 5th pulse with Target-Ema_In = 2^26 -> Gain_Out = 18'h10001.
REQ-026 Constant Ema_In well above Target (err = -2^40) -> gain decrements each update and stops at GAIN_MIN with Sat=1.
REQ-027 err=0 for 16 consecutive TRACK updates -> Locked rises after the 16th; one update with |err| >= LOCK_TH -> Locked=0 on the next cycle.
REQ-028 Gain 18'h3FFFF, Sample_In=27'h3FFFFFF -> Sample_Out = 27'h3FFFFFF (positive saturation); Sample_In=27'h4000000 -> 27'h4000000.
REQ-029 Loop_En dropped mid-TRACK and rst_n pulsed mid-stream -> gain holds on the enable drop; reset returns all outputs to REQ-022 values with no stale Valid_Out.
